irq_timer_ctrl: RTL and testbench

Parametrised interrupt source and controller sitting between the bench/SoC stimulus and the `mips` core's single `interrupt` input. It replaces the fixed, hand-driven interrupt line with NCH channels. Each channel is raised by an internal programmable down-counter timer (one-shot or periodic) or by a rising edge on an external source. Pending events are latched, masked and priority-encoded, and software clears them through a register write port.

---
 rtl/irq_timer_ctrl.sv | 147 ++++++++++++++
 tb/tb_irq_timer_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: NCH-channel interrupt source and controller.
// Each channel is raised by a programmable down-counter (one-shot or
// periodic) or by a rising edge on ext_irq. Pending events are latched,
// masked and priority-encoded (lowest index wins) onto a single interrupt.
module irq_timer_ctrl #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int ID_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [3:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NCH-1:0]  ext_irq,
  output logic            interrupt,
  output logic [ID_W-1:0] irq_id
);

  localparam logic [3:0] ADDR_MASK    = 4'h8;
  localparam logic [3:0] ADDR_MODE    = 4'h9;
  localparam logic [3:0] ADDR_PENDING = 4'hA;
  localparam logic [3:0] ADDR_OVERRUN = 4'hB;

  logic [CNT_W-1:0] count_q  [NCH];
  logic [CNT_W-1:0] count_d  [NCH];
  logic [CNT_W-1:0] period_q [NCH];
  logic [CNT_W-1:0] period_d [NCH];

  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] overrun_q, overrun_d;
  logic [NCH-1:0] ext_prev_q;

  logic [NCH-1:0] wr_period;
  logic [NCH-1:0] expiry;
  logic [NCH-1:0] ext_edge;
  logic [NCH-1:0] evt;
  logic [NCH-1:0] clr_pend;
  logic [NCH-1:0] clr_ovr;
  logic [NCH-1:0] active;
  logic           wr_mask;
  logic           wr_mode;

  // Upper wdata bits only matter for some registers; fold them so every bit is read.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Decode the write strobe into per-register enables and clear vectors.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_period = '0;
    wr_mask   = we && (addr == ADDR_MASK);
    wr_mode   = we && (addr == ADDR_MODE);
    clr_pend  = (we && (addr == ADDR_PENDING)) ? wdata[NCH-1:0] : '0;
    clr_ovr   = (we && (addr == ADDR_OVERRUN)) ? wdata[NCH-1:0] : '0;
    for (int i = 0; i < NCH; i++) begin
      wr_period[i] = we && !addr[3] && (addr[2:0] == 3'(i));
    end
  end

  // Per-channel down-counter; a period write overrides (and discards) an expiry.
  always_comb begin
    expiry = '0;
    for (int i = 0; i < NCH; i++) begin
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];
      if (wr_period[i]) begin
        count_d[i]  = wdata[CNT_W-1:0];
        period_d[i] = wdata[CNT_W-1:0];
      end else if (count_q[i] == CNT_W'(1)) begin
        expiry[i]  = 1'b1;
        count_d[i] = mode_q[i] ? period_q[i] : '0;
      end else if (count_q[i] != '0) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
    end
  end

  // Event merge: timer and edge coalesce; a new event beats a same-cycle clear.
  always_comb begin
    ext_edge  = ext_irq & ~ext_prev_q;
    evt       = expiry | ext_edge;
    pending_d = evt | (pending_q & ~clr_pend);
    overrun_d = (evt & pending_q & ~clr_pend) | (overrun_q & ~clr_ovr);
    mask_d    = wr_mask ? wdata[NCH-1:0] : mask_q;
    mode_d    = wr_mode ? wdata[NCH-1:0] : mode_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the count/period arrays are reset too, since reset must abandon any countdown in flight.
      for (int i = 0; i < NCH; i++) begin
        count_q[i]  <= '0;
        period_q[i] <= '0;
      end
      mask_q     <= '0;
      mode_q     <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      ext_prev_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      for (int i = 0; i < NCH; i++) begin
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      ext_prev_q <= ext_irq;
    end
  end

  // Masked interrupt and lowest-index priority encode.
  always_comb begin
    active    = pending_q & mask_q;
    interrupt = |active;
    irq_id    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (active[i]) irq_id = ID_W'(i);
    end
  end

  // Combinational register read; unmapped addresses return 0.
  always_comb begin
    rdata = '0;
    if (!addr[3]) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr[2:0] == 3'(i)) rdata = 32'(count_q[i]);
      end
    end else begin
      case (addr)
        ADDR_MASK:    rdata = 32'(mask_q);
        ADDR_MODE:    rdata = 32'(mode_q);
        ADDR_PENDING: rdata = 32'(pending_q);
        ADDR_OVERRUN: rdata = 32'(overrun_q);
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl. Stimulus pushes the expected
// rdata/interrupt/irq_id into a scoreboard queue; a monitor on the falling
// edge pops and compares whenever an expectation is outstanding.
module tb_irq_timer_ctrl;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;
  localparam int ID_W  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            we;
  logic [3:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [NCH-1:0]  ext_irq;
  logic            interrupt;
  logic [ID_W-1:0] irq_id;

  always #5 clk = ~clk;

  irq_timer_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ext_irq   (ext_irq),
    .interrupt (interrupt),
    .irq_id    (irq_id)
  );

  typedef struct {
    string           name;
    logic [31:0]     rd;
    logic            irq;
    logic [ID_W-1:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor: compare the DUT outputs against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (rdata !== mon_e.rd || interrupt !== mon_e.irq || irq_id !== mon_e.id) begin
        n_err++;
        $display("FAIL %s: got rdata=%h interrupt=%b irq_id=%0d, expected rdata=%h interrupt=%b irq_id=%0d",
                 mon_e.name, rdata, interrupt, irq_id, mon_e.rd, mon_e.irq, mon_e.id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register write: takes effect at the next rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    wdata = '0;
  endtask

  // Queue an expectation for the current state, then advance one edge.
  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp_rd,
                        input logic exp_irq, input logic [ID_W-1:0] exp_id);
    exp_t e;
    addr  = a;
    we    = 1'b0;
    e.name = nm;
    e.rd   = exp_rd;
    e.irq  = exp_irq;
    e.id   = exp_id;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    ext_irq = '0;

    // Reset then idle: every address reads 0, no interrupt.
    tick();
    tick();
    reset = 1'b0;
    repeat (34) tick();
    for (int a = 0; a < 16; a++) rd_chk("idle_rd", 4'(a), 32'h0, 1'b0, '0);

    // One-shot ch0, period 5: count 5,4,3,2,1 then 0 with pending at k+5.
    wr(4'h8, 32'h1);
    wr(4'h9, 32'h0);
    wr(4'h0, 32'd5);
    rd_chk("os_cnt5", 4'h0, 32'd5, 1'b0, '0);
    rd_chk("os_cnt4", 4'h0, 32'd4, 1'b0, '0);
    rd_chk("os_cnt3", 4'h0, 32'd3, 1'b0, '0);
    rd_chk("os_cnt2", 4'h0, 32'd2, 1'b0, '0);
    rd_chk("os_cnt1", 4'h0, 32'd1, 1'b0, '0);
    rd_chk("os_expire", 4'h0, 32'd0, 1'b1, 3'd0);
    rd_chk("os_pend", 4'hA, 32'h1, 1'b1, 3'd0);
    wr(4'hA, 32'h1);
    rd_chk("os_clr", 4'hA, 32'h0, 1'b0, '0);
    repeat (10) tick();
    rd_chk("os_no_reset", 4'hA, 32'h0, 1'b0, '0);
    rd_chk("os_no_ovr", 4'hB, 32'h0, 1'b0, '0);

    // Periodic ch1, period 3: pending at k+3, overrun at k+6.
    wr(4'h8, 32'h2);
    wr(4'h9, 32'h2);
    wr(4'h1, 32'd3);
    rd_chk("per_k0", 4'hA, 32'h0, 1'b0, '0);
    rd_chk("per_k1", 4'hA, 32'h0, 1'b0, '0);
    rd_chk("per_k2", 4'hA, 32'h0, 1'b0, '0);
    rd_chk("per_set", 4'hA, 32'h2, 1'b1, 3'd1);
    rd_chk("per_ovr_k4", 4'hB, 32'h0, 1'b1, 3'd1);
    rd_chk("per_ovr_k5", 4'hB, 32'h0, 1'b1, 3'd1);
    rd_chk("per_ovr_k6", 4'hB, 32'h2, 1'b1, 3'd1);
    wr(4'h1, 32'h0);
    wr(4'hA, 32'h2);
    wr(4'hB, 32'h2);
    rd_chk("per_pend_clr", 4'hA, 32'h0, 1'b0, '0);
    rd_chk("per_ovr_clr", 4'hB, 32'h0, 1'b0, '0);
    rd_chk("per_disarm", 4'h1, 32'h0, 1'b0, '0);
    rd_chk("per_mode_rd", 4'h9, 32'h2, 1'b0, '0);
    wr(4'h8, 32'h0);
    wr(4'h9, 32'h0);

    // Period write on the expiry edge: write wins, no pending.
    wr(4'h3, 32'd2);
    tick();
    wr(4'h3, 32'd3);
    rd_chk("wr_exp_pend", 4'hA, 32'h0, 1'b0, '0);
    rd_chk("wr_exp_cnt", 4'h3, 32'd2, 1'b0, '0);
    wr(4'h3, 32'h0);

    // Priority and mask with external edges on ch3 and ch1.
    wr(4'h8, 32'hA);
    ext_irq = 4'b1010;
    tick();
    rd_chk("prio_both", 4'hA, 32'hA, 1'b1, 3'd1);
    wr(4'hA, 32'h2);
    rd_chk("prio_ch3", 4'hA, 32'h8, 1'b1, 3'd3);
    wr(4'h8, 32'h0);
    rd_chk("prio_masked", 4'hA, 32'h8, 1'b0, '0);
    ext_irq = 4'b0000;
    tick();
    ext_irq = 4'b1000;
    tick();
    rd_chk("ext_ovr", 4'hB, 32'h8, 1'b0, '0);
    wr(4'h8, 32'h8);
    rd_chk("unmask_pend", 4'hA, 32'h8, 1'b1, 3'd3);
    ext_irq = 4'b0000;
    wr(4'hA, 32'h8);
    wr(4'hB, 32'h8);
    rd_chk("ext_clr", 4'hA, 32'h0, 1'b0, '0);
    wr(4'h8, 32'h0);

    // Clear-write on an expiry edge of periodic ch2: event wins, no overrun.
    wr(4'h8, 32'h4);
    wr(4'h9, 32'h4);
    wr(4'h2, 32'd4);
    rd_chk("col_cnt", 4'h2, 32'd4, 1'b0, '0);
    rd_chk("col_k1", 4'hA, 32'h0, 1'b0, '0);
    repeat (5) tick();
    wr(4'hA, 32'h4);
    rd_chk("col_pend", 4'hA, 32'h4, 1'b1, 3'd2);
    rd_chk("col_ovr", 4'hB, 32'h0, 1'b1, 3'd2);
    wr(4'h2, 32'h0);
    wr(4'hA, 32'h4);
    wr(4'h8, 32'h0);
    wr(4'h9, 32'h0);

    // Reset mid-count abandons the countdown.
    wr(4'h0, 32'd10);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    rd_chk("rst_pend", 4'hA, 32'h0, 1'b0, '0);
    rd_chk("rst_cnt", 4'h0, 32'h0, 1'b0, '0);
    rd_chk("rst_period_chk", 4'h0, 32'h0, 1'b0, '0);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations still queued, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
